conv33_line_feeder: RTL and testbench

Raster-to-column feeder for the 3x3 convolution window. It accepts one pixel per cycle of a row-major image stream and buffers the two previous image rows internally. For each pixel of image row 2 or later, it drives the three vertically adjacent pixels (rows r-2, r-1, r) plus the latch enable into the convolution window. It also flags the cycle in which the window's `convValue` corresponds to a complete, in-bounds 3x3 patch.

---
 rtl/conv33_line_feeder_if.sv | 35 +++
 rtl/conv33_line_feeder.sv | 118 +++++++++++
 tb/tb_conv33_line_feeder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/conv33_line_feeder_if.sv
// Pixel stream and window-feed bundle for conv33_line_feeder.
// Handshake: valid-only, with no ready and no backpressure. pix_in, sof and
// pix_valid are sampled at each rising edge, and a pixel is consumed at
// every edge where pix_valid is high. en and win_valid are single-cycle
// strobes, and each one qualifies its companion data for that cycle only.
interface conv33_line_feeder_if #(
  parameter int BIT_WIDTH  = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic                 sof;
  logic                 pix_valid;
  logic [BIT_WIDTH-1:0] pix_in;
  logic                 en;
  logic [BIT_WIDTH-1:0] in1;
  logic [BIT_WIDTH-1:0] in2;
  logic [BIT_WIDTH-1:0] in3;
  logic                 win_valid;
  logic [RW-1:0]        win_row;
  logic [CW-1:0]        win_col;
  logic                 frame_done;

  modport master (
    output sof, pix_valid, pix_in,
    input  en, in1, in2, in3, win_valid, win_row, win_col, frame_done
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output en, in1, in2, in3, win_valid, win_row, win_col, frame_done
  );
endinterface

// File: rtl/conv33_line_feeder.sv
// Raster-to-column feeder for a 3x3 convolution window. The block keeps two
// row buffers and, for each pixel of image row 2 or later, presents the
// vertical triple (r-2, r-1, r). It also flags the cycle in which the
// window holds a complete, in-bounds 3x3 patch.
module conv33_line_feeder #(
  parameter int BIT_WIDTH  = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input logic                 clk,
  input logic                 rst,
  conv33_line_feeder_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  // Position counters (next pixel to be accepted) and the position of the
  // pixel on the bus this cycle, with sof overriding the counters.
  logic [CW-1:0] col, col_nxt, pix_col, pix_col_q;
  logic [RW-1:0] row, row_nxt, pix_row, pix_row_q;
  logic          last_col, last_pix;

  // Output registers.
  logic                 en_q, win_valid_q, frame_done_q;
  logic [BIT_WIDTH-1:0] in1_q, in2_q, in3_q;
  logic [RW-1:0]        win_row_q;
  logic [CW-1:0]        win_col_q;

  // Line buffers: lb0 holds row r-1 and lb1 holds row r-2. They are not
  // reset, because rows 0 and 1 of every frame rewrite them before use.
  logic [BIT_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [BIT_WIDTH-1:0] lb1 [IMG_WIDTH];

  // Resolve the current pixel position and the next counter state.
  always_comb begin
    pix_col  = bus.sof ? '0 : col;
    pix_row  = bus.sof ? '0 : row;
    last_col = (pix_col == COL_LAST);
    last_pix = last_col && (pix_row == ROW_LAST);
    col_nxt  = col;
    row_nxt  = row;
    if (bus.pix_valid) begin
      if (last_col) begin
        col_nxt = '0;
        row_nxt = last_pix ? '0 : pix_row + RW'(1);
      end else begin
        col_nxt = pix_col + CW'(1);
        row_nxt = pix_row;
      end
    end else if (bus.sof) begin
      col_nxt = '0;
      row_nxt = '0;
    end
  end

  // Counters, strobes and window coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      pix_col_q    <= '0;
      pix_row_q    <= '0;
      en_q         <= 1'b0;
      frame_done_q <= 1'b0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      col          <= col_nxt;
      row          <= row_nxt;
      en_q         <= bus.pix_valid && (pix_row >= RW'(2));
      frame_done_q <= bus.pix_valid && last_pix;
      if (bus.pix_valid) begin
        pix_col_q <= pix_col;
        pix_row_q <= pix_row;
      end
      // Columns 0 and 1 still carry columns of the previous row in the
      // window, so only a pixel at column 2 or later completes a patch.
      win_valid_q <= en_q && (pix_col_q >= CW'(2));
      if (en_q && (pix_col_q >= CW'(2))) begin
        win_row_q <= pix_row_q - RW'(2);
        win_col_q <= pix_col_q - CW'(2);
      end
    end
  end

  // Column data to the window, held when no pixel is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      in1_q <= '0;
      in2_q <= '0;
      in3_q <= '0;
    end else if (bus.pix_valid) begin
      in1_q <= lb1[pix_col];
      in2_q <= lb0[pix_col];
      in3_q <= bus.pix_in;
    end
  end

  // Shift the column down the line buffers. Reads above use pre-edge data.
  always_ff @(posedge clk) begin
    if (!rst && bus.pix_valid) begin
      lb1[pix_col] <= lb0[pix_col];
      lb0[pix_col] <= bus.pix_in;
    end
  end

  assign bus.en         = en_q;
  assign bus.in1        = in1_q;
  assign bus.in2        = in2_q;
  assign bus.in3        = in3_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_conv33_line_feeder.sv
// Bench for conv33_line_feeder on a 4x4 image with pixel (r,c) = base+4r+c+1.
// Drivers push cycle-stamped expectations, and a negedge monitor pops them
// and compares them against en, win_valid and frame_done strobes.
module tb_conv33_line_feeder;
  localparam int BW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Entry formats: en {stamp16, in1, in2, in3}, window {stamp16, row, col},
  // and frame_done {stamp16}.
  logic [39:0] exp_en_q[$];
  logic [19:0] exp_win_q[$];
  logic [15:0] exp_fd_q[$];

  conv33_line_feeder_if #(.BIT_WIDTH(BW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

  conv33_line_feeder #(.BIT_WIDTH(BW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and cycle counter. At the negedge following edge k, cyc equals k.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pv(input int base, input int r, input int c);
    return 8'(base + 4 * r + c + 1);
  endfunction

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.sof       = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_in    = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic drive_pix(input int base, input int r, input int c, input bit s);
    int k;
    @(negedge clk);
    bus.sof       = s;
    bus.pix_valid = 1'b1;
    bus.pix_in    = pv(base, r, c);
    k = cyc + 1;
    if (r >= 2) exp_en_q.push_back({16'(k), pv(base, r - 2, c), pv(base, r - 1, c), pv(base, r, c)});
    if (r >= 2 && c >= 2) exp_win_q.push_back({16'(k + 1), 2'(r - 2), 2'(c - 2)});
    if (r == H - 1 && c == W - 1) exp_fd_q.push_back(16'(k));
  endtask

  // Sends pixels 0..stop_n-1 in raster order. Optional random gaps come
  // before each pixel.
  task automatic send_frame(input int base, input bit use_sof, input bit gaps, input int stop_n);
    for (int n = 0; n < stop_n; n++) begin
      if (gaps) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 1) == 1) idle(1);
          else break;
        end
      end
      drive_pix(base, n / W, n % W, use_sof && (n == 0));
    end
  endtask

  // Monitor: every strobe must match the head of its queue, stamp included.
  always @(negedge clk) begin
    if (bus.en === 1'b1) begin
      if (exp_en_q.size() == 0) check("en_unexpected", {cyc[15:0], bus.in1, bus.in2, bus.in3}, 40'h0);
      else check("en_column", {cyc[15:0], bus.in1, bus.in2, bus.in3}, exp_en_q.pop_front());
    end
    if (bus.win_valid === 1'b1) begin
      if (exp_win_q.size() == 0) check("win_unexpected", {20'h0, cyc[15:0], bus.win_row, bus.win_col}, 40'h0);
      else check("win_pos", {20'h0, cyc[15:0], bus.win_row, bus.win_col}, {20'h0, exp_win_q.pop_front()});
    end
    if (bus.frame_done === 1'b1) begin
      if (exp_fd_q.size() == 0) check("fd_unexpected", {24'h0, cyc[15:0]}, 40'h0);
      else check("frame_done", {24'h0, cyc[15:0]}, {24'h0, exp_fd_q.pop_front()});
    end
  end

  initial begin
    // Hold reset with pix_valid high. All outputs must then read as zero.
    bus.sof       = 1'b0;
    bus.pix_valid = 1'b1;
    bus.pix_in    = 8'd55;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_en",   {39'h0, bus.en},         40'h0);
    check("rst_in1",  {32'h0, bus.in1},        40'h0);
    check("rst_in2",  {32'h0, bus.in2},        40'h0);
    check("rst_in3",  {32'h0, bus.in3},        40'h0);
    check("rst_win",  {39'h0, bus.win_valid},  40'h0);
    check("rst_row",  {38'h0, bus.win_row},    40'h0);
    check("rst_col",  {38'h0, bus.win_col},    40'h0);
    check("rst_fd",   {39'h0, bus.frame_done}, 40'h0);
    rst           = 1'b0;
    bus.pix_valid = 1'b0;

    // First frame after reset has no sof, so counters must start at (0,0).
    send_frame(0, 1'b0, 1'b0, W * H);
    idle(3);
    // Continuous frame with sof on the first pixel.
    send_frame(0, 1'b1, 1'b0, W * H);
    idle(3);
    // Same frame with random gaps between pixels.
    send_frame(0, 1'b1, 1'b1, W * H);
    idle(3);
    // Frame A is abandoned at (3,1) by the sof of frame B.
    send_frame(0, 1'b1, 1'b0, 3 * W + 1);
    send_frame(100, 1'b1, 1'b0, W * H);
    idle(3);

    // Reset lands on the slot of pixel (2,3). That pixel is never accepted,
    // and the window pending for (2,2) is cancelled.
    send_frame(0, 1'b1, 1'b0, 2 * W + 3);
    @(negedge clk);
    rst           = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_in    = pv(0, 2, 3);
    while (exp_win_q.size() > 0 && exp_win_q[exp_win_q.size() - 1][19:4] >= 16'(cyc + 1))
      void'(exp_win_q.pop_back());
    @(negedge clk);
    check("midrst_en",  {39'h0, bus.en},        40'h0);
    check("midrst_win", {39'h0, bus.win_valid}, 40'h0);
    rst           = 1'b0;
    bus.pix_valid = 1'b0;
    send_frame(0, 1'b0, 1'b0, W * H);
    idle(2);

    // Back-to-back frames with no idle cycles between them.
    send_frame(200, 1'b1, 1'b0, W * H);
    send_frame(50, 1'b1, 1'b0, W * H);
    idle(6);

    check("en_left",  {8'h0, 32'(exp_en_q.size())},  40'h0);
    check("win_left", {8'h0, 32'(exp_win_q.size())}, 40'h0);
    check("fd_left",  {8'h0, 32'(exp_fd_q.size())},  40'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
